// File: rtl/jtag_config_loader_if.sv
// jtag_config_loader_if
//   TAP-side word channel feeding the configuration loader.
//   active        : PROGRAM instruction in progress (TCK domain, async to clk)
//   config_strobe : rising edge marks a new word (TCK domain)
//   config_data   : 32-bit word, stable from strobe rise until strobe fall
//   master modport: driven by the TAP; slave modport: consumed by the loader.
interface jtag_config_loader_if;
  logic        active;
  logic        config_strobe;
  logic [31:0] config_data;

  modport master (output active, output config_strobe, output config_data);
  modport slave  (input  active, input  config_strobe, input  config_data);
endinterface

// File: rtl/jtag_config_loader.sv
// jtag_config_loader
//   Receives framed configuration packets from the JTAG TAP, resynchronises
//   the TCK-domain strobe into clk, stages the payload in a shadow bank and
//   commits it atomically to the live registers when the XOR checksum matches.
//   Packet: header {8'hA5, start S, count N, 8'h00}, N payload words, then a
//   checksum word equal to the XOR of the header and all payload words.
//
// Ports
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   tap         : TAP word channel (active / config_strobe / config_data)
//   cfg_regs    : live registers, reg i at [32i+31:32i]
//   cfg_valid   : at least one packet committed since reset
//   apply_pulse : one-clk pulse when a commit lands in cfg_regs
//   load_error  : sticky error, cleared by the next accepted header
//   busy        : FSM is outside IDLE
//
// FSM states
//   state   | meaning
//   IDLE    | waiting for a header word (ignored while active is low)
//   PAYLOAD | writing payload words into the shadow bank
//   CHECK   | waiting for the checksum word
//   COMMIT  | single cycle: copy shadow range into cfg_regs
module jtag_config_loader #(
  parameter int NUM_REGS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  jtag_config_loader_if.slave       tap,
  output logic [NUM_REGS*32-1:0]    cfg_regs,
  output logic                      cfg_valid,
  output logic                      apply_pulse,
  output logic                      load_error,
  output logic                      busy
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CHECK   = 2'd2,
    S_COMMIT  = 2'd3
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------
  // Strobe / active resynchronisation
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] strobe_sync;
  logic [SYNC_STAGES-1:0] active_sync;
  logic                   strobe_prev;
  logic                   active_prev;
  logic                   strobe_s;
  logic                   active_s;
  logic                   evt_raw;
  logic                   active_fall;
  logic                   word_evt;
  logic [31:0]            data_hold;

  assign strobe_s    = strobe_sync[SYNC_STAGES-1];
  assign active_s    = active_sync[SYNC_STAGES-1];
  assign evt_raw     = strobe_s & ~strobe_prev;
  assign active_fall = active_prev & ~active_s;

  // config_data has been stable for SYNC_STAGES clocks when evt_raw fires,
  // so it is safe to sample directly. word_evt is registered alongside the
  // holding register so the FSM always sees a word that is already captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_sync <= '0;
      active_sync <= '0;
      strobe_prev <= 1'b0;
      active_prev <= 1'b0;
      word_evt    <= 1'b0;
      data_hold   <= '0;
    end else begin
      strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], tap.config_strobe};
      active_sync <= {active_sync[SYNC_STAGES-2:0], tap.active};
      strobe_prev <= strobe_s;
      active_prev <= active_s;
      word_evt    <= evt_raw;
      if (evt_raw) begin
        data_hold <= tap.config_data;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Header decode
  // ---------------------------------------------------------------------
  logic [7:0] hdr_sync;
  logic [7:0] hdr_start;
  logic [7:0] hdr_count;
  logic [7:0] hdr_rsvd;
  logic [8:0] hdr_end;
  logic       hdr_ok;

  assign hdr_sync  = data_hold[31:24];
  assign hdr_start = data_hold[23:16];
  assign hdr_count = data_hold[15:8];
  assign hdr_rsvd  = data_hold[7:0];
  assign hdr_end   = {1'b0, hdr_start} + {1'b0, hdr_count};

  // 9-bit end address makes S+N overflow visible instead of wrapping.
  assign hdr_ok = (hdr_sync == 8'hA5) && (hdr_rsvd == 8'h00) &&
                  (hdr_count != 8'h00) &&
                  ({1'b0, hdr_count} <= 9'(NUM_REGS)) &&
                  (hdr_end <= 9'(NUM_REGS));

  // ---------------------------------------------------------------------
  // Packet context
  // ---------------------------------------------------------------------
  logic [AW-1:0] ptr;
  logic [7:0]    remaining;
  logic [7:0]    pkt_start;
  logic [7:0]    pkt_count;
  logic [31:0]   xor_acc;
  logic [31:0]   shadow [NUM_REGS];
  logic [31:0]   cfg_q  [NUM_REGS];

  logic hdr_accept;
  logic hdr_reject;
  logic pay_write;
  logic chk_fail;
  logic abort_evt;
  logic commit_en;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    hdr_accept = 1'b0;
    hdr_reject = 1'b0;
    pay_write  = 1'b0;
    chk_fail   = 1'b0;
    abort_evt  = 1'b0;
    commit_en  = 1'b0;
    case (state)
      S_IDLE: begin
        if (word_evt && active_s) begin
          if (hdr_ok) begin
            hdr_accept = 1'b1;
            state_next = S_PAYLOAD;
          end else begin
            hdr_reject = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        // Abort wins over a word arriving in the same cycle.
        if (active_fall) begin
          abort_evt  = 1'b1;
          state_next = S_IDLE;
        end else if (word_evt) begin
          pay_write = 1'b1;
          if (remaining == 8'd1) begin
            state_next = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (active_fall) begin
          abort_evt  = 1'b1;
          state_next = S_IDLE;
        end else if (word_evt) begin
          if (data_hold == xor_acc) begin
            state_next = S_COMMIT;
          end else begin
            chk_fail   = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_COMMIT: begin
        commit_en  = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Commit window: only the range named by the current header is copied.
  // Stale shadow entries from a failed packet lie outside any later range
  // unless rewritten first, so no explicit discard is needed.
  // ---------------------------------------------------------------------
  logic [NUM_REGS-1:0] commit_mask;
  logic [8:0]          pkt_end;

  assign pkt_end = {1'b0, pkt_start} + {1'b0, pkt_count};

  always_comb begin
    commit_mask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      commit_mask[i] = (9'(i) >= {1'b0, pkt_start}) && (9'(i) < pkt_end);
    end
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr         <= '0;
      remaining   <= '0;
      pkt_start   <= '0;
      pkt_count   <= '0;
      xor_acc     <= '0;
      cfg_valid   <= 1'b0;
      apply_pulse <= 1'b0;
      load_error  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
        cfg_q[i]  <= '0;
      end
    end else begin
      apply_pulse <= commit_en;

      if (hdr_accept) begin
        xor_acc   <= data_hold;
        ptr       <= hdr_start[AW-1:0];
        remaining <= hdr_count;
        pkt_start <= hdr_start;
        pkt_count <= hdr_count;
      end

      if (pay_write) begin
        shadow[ptr] <= data_hold;
        xor_acc     <= xor_acc ^ data_hold;
        ptr         <= ptr + 1'b1;
        remaining   <= remaining - 8'd1;
      end

      if (commit_en) begin
        cfg_valid <= 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (commit_mask[i]) begin
            cfg_q[i] <= shadow[i];
          end
        end
      end

      if (hdr_reject || chk_fail || abort_evt) begin
        load_error <= 1'b1;
      end else if (hdr_accept) begin
        load_error <= 1'b0;
      end
    end
  end

  assign busy = (state != S_IDLE);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign cfg_regs[g*32 +: 32] = cfg_q[g];
  end

endmodule

// File: tb/tb_jtag_config_loader.sv
// Testbench for jtag_config_loader: randomized packets against a packet-level
// reference model; expected commit/error events are queued at stimulus time
// and a separate monitor compares them when the DUT signals them.
module tb_jtag_config_loader;
  localparam int NUM_REGS    = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CLK_P       = 10;
  localparam int W           = NUM_REGS * 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] cfg_regs;
  logic         cfg_valid, apply_pulse, load_error, busy;

  always #(CLK_P/2) clk = ~clk;

  jtag_config_loader_if tap_if();

  jtag_config_loader #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset_n(reset_n), .tap(tap_if.slave),
    .cfg_regs(cfg_regs), .cfg_valid(cfg_valid), .apply_pulse(apply_pulse),
    .load_error(load_error), .busy(busy));

  typedef struct {
    bit           is_commit;
    logic [W-1:0] regs;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_regs [NUM_REGS];
  bit          model_valid;
  bit          model_err;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model_flat();
    logic [W-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*32 +: 32] = model_regs[i];
    return f;
  endfunction

  task automatic push_event(input bit is_commit);
    exp_t e;
    e.is_commit = is_commit;
    e.regs      = model_flat();
    exp_q.push_back(e);
  endtask

  // An error event is only visible when load_error rises.
  task automatic expect_error();
    if (!model_err) push_event(1'b0);
    model_err = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    bit   err_prev;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (apply_pulse) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_commit: got apply_pulse=1 expected no event");
          end else begin
            e = exp_q.pop_front();
            check("event_is_commit", 1'b1, e.is_commit);
            check("cfg_regs_commit", cfg_regs, e.regs);
            check("cfg_valid_commit", cfg_valid, 1'b1);
            check("load_error_commit", load_error, 1'b0);
            check("busy_at_apply", busy, 1'b0);
          end
        end
        if (load_error && !err_prev) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_error: got load_error rise expected no event");
          end else begin
            e = exp_q.pop_front();
            check("event_is_error", 1'b0, e.is_commit);
            check("cfg_regs_error", cfg_regs, e.regs);
          end
        end
      end
      err_prev = load_error;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_word(input logic [31:0] w, input bit exact_width);
    int ph, hi, lo;
    tap_if.config_data = w;
    ph = int'($urandom_range(1, CLK_P - 1));
    #(ph);
    tap_if.config_strobe = 1'b1;
    hi = (SYNC_STAGES + 2) * CLK_P + (exact_width ? 0 : int'($urandom_range(0, 15)));
    lo = (SYNC_STAGES + 2) * CLK_P + (exact_width ? 0 : int'($urandom_range(0, 15)));
    #(hi);
    tap_if.config_strobe = 1'b0;
    tap_if.config_data   = $urandom;
    #(lo);
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: got %0d pending events expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // kind: 0 good, 1 bad checksum, 3 abort after k payload words
  task automatic send_packet(input int s, input int n, input int kind, input int k,
                             input logic [31:0] fixed [], input logic [31:0] csum_flip);
    logic [31:0] hdr, sum;
    logic [31:0] pay [];
    hdr = {8'hA5, 8'(s), 8'(n), 8'h00};
    pay = new[n];
    sum = hdr;
    for (int j = 0; j < n; j++) begin
      pay[j] = (fixed.size() == n) ? fixed[j] : $urandom;
      sum    = sum ^ pay[j];
    end
    model_err = 1'b0;
    if (kind == 0) begin
      for (int j = 0; j < n; j++) model_regs[s + j] = pay[j];
      model_valid = 1'b1;
      push_event(1'b1);
    end else if (kind == 1) begin
      expect_error();
    end
    send_word(hdr, $urandom_range(0, 1) == 1);
    if (kind == 3) begin
      for (int j = 0; j < k; j++) send_word(pay[j], $urandom_range(0, 1) == 1);
      expect_error();
      tap_if.active = 1'b0;
      repeat (10) @(negedge clk);
      tap_if.active = 1'b1;
      repeat (6) @(negedge clk);
    end else begin
      for (int j = 0; j < n; j++) send_word(pay[j], $urandom_range(0, 1) == 1);
      send_word(sum ^ csum_flip, $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic send_bad_header(input logic [31:0] w);
    expect_error();
    send_word(w, 1'b1);
  endtask

  function automatic logic [31:0] random_bad_header();
    int v, n, s;
    logic [7:0] b;
    v = int'($urandom_range(0, 4));
    n = int'($urandom_range(1, NUM_REGS));
    s = int'($urandom_range(0, NUM_REGS - n));
    case (v)
      0: return {8'hA5, 8'(s), 8'h00, 8'h00};
      1: return {8'hA5, 8'($urandom_range(NUM_REGS - n + 1, 255)), 8'(n), 8'h00};
      2: begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        return {b, 8'(s), 8'(n), 8'h00};
      end
      3: return {8'hA5, 8'(s), 8'(n), 8'($urandom_range(1, 255))};
      default: return {8'hA5, 8'h00, 8'($urandom_range(NUM_REGS + 1, 255)), 8'h00};
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin : stim
    logic [31:0] none [];
    logic [31:0] p3 [];
    logic [31:0] w;
    int n, s, kind;
    none = new[0];
    p3   = new[3];
    p3[0] = 32'h11111111; p3[1] = 32'h22222222; p3[2] = 32'h33333333;
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
    model_valid = 1'b0;
    model_err   = 1'b0;
    tap_if.active        = 1'b0;
    tap_if.config_strobe = 1'b0;
    tap_if.config_data   = '0;

    repeat (3) @(negedge clk);
    check("reset_cfg_regs", cfg_regs, '0);
    check("reset_cfg_valid", cfg_valid, 1'b0);
    check("reset_apply_pulse", apply_pulse, 1'b0);
    check("reset_load_error", load_error, 1'b0);
    check("reset_busy", busy, 1'b0);
    #3 reset_n = 1'b1;
    tap_if.active = 1'b1;
    repeat (6) @(negedge clk);

    // good packet
    send_packet(2, 3, 0, 0, p3, 32'h0);
    wait_drain("good_packet");
    check("good_regs", cfg_regs, model_flat());

    // bad checksum, then recovery
    send_packet(2, 3, 1, 0, p3, 32'h1);
    wait_drain("bad_checksum");
    check("badsum_error", load_error, 1'b1);
    send_packet(0, 2, 0, 0, none, 32'h0);
    wait_drain("recover_packet");

    // header rejects, then junk words that must not be taken as headers
    send_bad_header({8'hA5, 8'd6, 8'd3, 8'h00});
    send_bad_header({8'hA5, 8'd2, 8'd0, 8'h00});
    send_bad_header({8'h5A, 8'd2, 8'd3, 8'h00});
    for (int j = 0; j < 3; j++) begin
      w = $urandom;
      w[31:24] = 8'h3C;
      send_bad_header(w);
    end
    wait_drain("header_reject");
    check("reject_busy", busy, 1'b0);
    check("reject_error", load_error, 1'b1);

    // abort after one payload word, with busy observed mid-packet
    model_err = 1'b0;
    send_word({8'hA5, 8'd1, 8'd3, 8'h00}, 1'b1);
    send_word(32'hDEADBEEF, 1'b1);
    repeat (2) @(negedge clk);
    check("busy_mid_packet", busy, 1'b1);
    expect_error();
    tap_if.active = 1'b0;
    wait_drain("abort");
    check("abort_busy", busy, 1'b0);
    check("abort_regs", cfg_regs, model_flat());
    // words while active is low are ignored entirely
    send_word({8'hA5, 8'd0, 8'd1, 8'h00}, 1'b0);
    send_word(32'h12345678, 1'b0);
    send_word({8'hA5, 8'd0, 8'd1, 8'h00} ^ 32'h12345678, 1'b0);
    repeat (10) @(negedge clk);
    check("inactive_regs", cfg_regs, model_flat());
    check("inactive_error", load_error, 1'b1);
    tap_if.active = 1'b1;
    repeat (6) @(negedge clk);

    // randomized packets
    for (int t = 0; t < 30; t++) begin
      kind = int'($urandom_range(0, 3));
      n = int'($urandom_range(1, NUM_REGS));
      s = int'($urandom_range(0, NUM_REGS - n));
      if (kind == 2) send_bad_header(random_bad_header());
      else if (kind == 1) send_packet(s, n, 1, 0, none, 32'h1 << $urandom_range(0, 31));
      else send_packet(s, n, kind, int'($urandom_range(0, n)), none, 32'h0);
      wait_drain("random_packet");
    end
    send_packet(0, NUM_REGS, 0, 0, none, 32'h0);
    wait_drain("full_bank");

    // reset in the middle of PAYLOAD
    model_err = 1'b0;
    send_word({8'hA5, 8'd3, 8'd4, 8'h00}, 1'b1);
    send_word($urandom, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_cfg_regs", cfg_regs, '0);
    check("midreset_cfg_valid", cfg_valid, 1'b0);
    check("midreset_load_error", load_error, 1'b0);
    check("midreset_busy", busy, 1'b0);
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
    model_valid = 1'b0;
    repeat (3) @(negedge clk);
    #3 reset_n = 1'b1;
    repeat (6) @(negedge clk);
    send_packet(5, 3, 0, 0, none, 32'h0);
    wait_drain("post_reset");

    check("final_regs", cfg_regs, model_flat());
    check("final_valid", cfg_valid, model_valid);
    check("final_error", load_error, model_err);
    check("final_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #(CLK_P * 90000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jtag_config_loader.md
# jtag_config_loader

Consumes the 32-bit configuration words that the JTAG TAP emits on `config_data`/`config_strobe` while its PROGRAM instruction is running. It resynchronises the TCK-domain strobe into the system clock domain and parses a framed packet: header, payload words, XOR checksum. Payload is staged in a shadow bank and committed atomically to the live configuration registers only when the checksum matches. The block sits directly downstream of the TAP and upstream of all logic reading `cfg_regs`.

## Interface
- `NUM_REGS`, default 8: number of 32-bit configuration registers; power of two, 2..256.
- `SYNC_STAGES`, default 2: flops in the strobe synchroniser; minimum 2.
- `clk` input 1: system clock; all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset. Clears all state.
- `active` input 1: TAP `active`, meaning PROGRAM is in progress. Asynchronous; synchronised like the strobe.
- `config_strobe` input 1: TAP word strobe. TCK domain; rising edge marks a new word.
- `config_data` input 32: TAP word. Stable from strobe rise until strobe fall.
- `cfg_regs` output NUM_REGS*32: live registers, with reg i at bits [32i+31:32i].
- `cfg_valid` output 1: high once at least one packet has committed since reset.
- `apply_pulse` output 1: one-clk pulse on the cycle the commit takes effect.
- `load_error` output 1: sticky error flag. Cleared by the next accepted header.
- `busy` output 1: high when the FSM is not in IDLE.

## Operation
- **Strobe capture**
  - `config_strobe` passes through SYNC_STAGES flops plus one edge flop.
  - A synchronised rising edge produces `word_evt`.
  - `config_data` is sampled into a holding register on `word_evt`. Data is stable there by the strobe-width rule in Timing.
- **Packet format**
  - Header: [31:24] = 8'hA5; [23:16] = start address S; [15:8] = count N; [7:0] = 8'h00.
  - Payload: N words.
  - Checksum: one word equal to the XOR of the header and all N payload words.
- **FSM states**
  - IDLE
    - On `word_evt`, validate the header.
    - Valid header: clear `load_error`, clear the running XOR to the header value, set ptr = S and remaining = N, go to PAYLOAD.
    - Valid means: sync byte is A5, reserved byte is 0, 1 ≤ N ≤ NUM_REGS, and S+N ≤ NUM_REGS. No wrap-around is permitted.
    - Invalid header: set `load_error` and stay in IDLE.
  - PAYLOAD
    - On each `word_evt`: write shadow[ptr], XOR the word into the running XOR, ptr++, remaining--.
    - When remaining reaches 0, go to CHECK.
  - CHECK
    - On `word_evt`, compare the word with the running XOR.
    - Equal: go to COMMIT.
    - Unequal: set `load_error`, discard the shadow writes, go to IDLE.
  - COMMIT (one cycle)
    - Copy shadow[S..S+N-1] into `cfg_regs`; all other regs keep their values.
    - Assert `apply_pulse` and set `cfg_valid`, then go to IDLE.
- **Abort**
  - Synchronised `active` falling while the FSM is in PAYLOAD or CHECK sets `load_error` and returns to IDLE. No commit occurs.
  - `active` low while in IDLE ignores `word_evt`.
- **Simultaneous events**
  - Abort takes priority over a `word_evt` in the same cycle.
  - COMMIT ignores `word_evt`. The TAP's strobe spacing guarantees none arrives then.
- Shadow bank is not observable and is not reset-cleared beyond its 0 reset value.

## Timing
- **Reset values**: `cfg_regs` = 0, `cfg_valid` = 0, `apply_pulse` = 0, `load_error` = 0, `busy` = 0; FSM in IDLE.
- **Mid-packet reset**: aborts immediately with no commit.
- **Strobe requirements**: `config_strobe` high for ≥ SYNC_STAGES+2 clk periods and low for ≥ SYNC_STAGES+2 clk periods between words.
- **Strobe latency**: from strobe rise to `word_evt` is SYNC_STAGES+1 clk. Word processing occurs in the same cycle as `word_evt`.
- **Commit latency**: checksum `word_evt` → COMMIT state on the next clk. `cfg_regs` update and `apply_pulse` are registered and visible one clk after COMMIT entry.
- **Timing of other flags**:
  - `busy` rises one clk after the header `word_evt` and falls with `apply_pulse`.
  - `load_error` asserts one clk after the offending `word_evt` or abort detection.

## Test plan
- **Good packet**: header A5_02_03_00, payload 11111111/22222222/33333333, checksum = XOR → regs 2..4 updated, others 0, one `apply_pulse`, `cfg_valid` = 1, `load_error` = 0.
- **Bad checksum**: same packet with checksum ^ 1 → `cfg_regs` unchanged, `load_error` = 1, no pulse. A following good packet clears `load_error` and commits.
- **Header rejects**: S = 6, N = 3 with NUM_REGS = 8; N = 0; sync byte = 5A → `load_error` = 1, `busy` stays 0, and subsequent words are ignored as headers until valid.
- **Abort**: drop `active` after 1 of 3 payload words → FSM returns to IDLE, `load_error` = 1, `cfg_regs` unchanged.
- **Reset mid-packet**: assert `reset_n` = 0 during PAYLOAD → all outputs 0 asynchronously. A fresh good packet then commits normally.
- **Strobe CDC**: strobe width exactly SYNC_STAGES+2 clk with an asynchronous tck phase sweep → every word accepted exactly once and no duplicate `word_evt`.
